lock_sequencer: RTL and testbench

//  Door-lock control FSM sitting directly behind synckey. Consumes the 5-bit key code and
//  key-held strobe, assembles PIN digits, compares against a stored PIN and drives unlock/alarm.

---
 rtl/lock_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_lock_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_sequencer.sv
// lock_sequencer: PIN-entry door-lock FSM fed by synckey (5-bit key code plus key-held strobe).
// Define AUTO_RELOCK_EN to add an idle timer that relocks the door from OPEN.
//
// state   | meaning
// LOCKED  | door locked, waiting for the first digit
// ENTRY   | collecting PIN digits for an unlock attempt
// OPEN    | door unlocked
// SET_NEW | door unlocked, collecting a replacement PIN
// ALARM   | timed lockout after too many bad attempts, all keys ignored
module lock_sequencer #(
    parameter int                  PW_LEN        = 4,
    parameter logic [PW_LEN*4-1:0] DEFAULT_PW    = 16'h1234,
    parameter int                  MAX_FAIL      = 3,
    parameter int                  ALARM_CYCLES  = 1000,
    parameter int                  RELOCK_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe,
    input  logic [4:0] key,
    output logic       unlocked,
    output logic       alarm,
    output logic [2:0] state,
    output logic [2:0] digit_cnt,
    output logic [1:0] fail_cnt
);
    localparam int             PWW        = PW_LEN * 4;
    localparam int             AW         = $clog2(ALARM_CYCLES + 1);
    localparam logic [2:0]     PW_LEN_C   = 3'(PW_LEN);
    localparam logic [1:0]     MAX_FAIL_C = 2'(MAX_FAIL);
    localparam logic [AW-1:0]  ALARM_LAST = AW'(ALARM_CYCLES - 1);
    localparam logic [4:0]     K_ENTER    = 5'd16;
    localparam logic [4:0]     K_CLEAR    = 5'd17;
    localparam logic [4:0]     K_LOCK     = 5'd18;
    localparam logic [4:0]     K_SET      = 5'd19;

    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_ENTRY   = 3'd1,
        S_OPEN    = 3'd2,
        S_SET_NEW = 3'd3,
        S_ALARM   = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_strobe_q;
    logic            r_unlocked;
    logic            r_alarm;
    logic [PWW-1:0]  r_buf;
    logic [PWW-1:0]  r_pin;
    logic [2:0]      r_digit_cnt;
    logic [1:0]      r_fail_cnt;
    logic [AW-1:0]   r_alarm_cnt;
`ifdef AUTO_RELOCK_EN
    localparam int             RW          = $clog2(RELOCK_CYCLES + 1);
    localparam logic [RW-1:0]  RELOCK_LAST = RW'(RELOCK_CYCLES - 1);
    logic [RW-1:0]   r_relock_cnt;
`endif

    logic            w_press;
    logic            w_is_digit;
    logic            w_digit_room;
    logic            w_match;
    logic            w_fail_hit;
    logic [PWW-1:0]  w_buf_shift;

    // A held key produces exactly one press event, on its rising strobe edge.
    assign w_press      = strobe & ~r_strobe_q;
    assign w_is_digit   = ~key[4];
    assign w_digit_room = (r_digit_cnt < PW_LEN_C);
    assign w_buf_shift  = (r_buf << 4) | PWW'(key[3:0]);
    assign w_match      = (r_digit_cnt == PW_LEN_C) && (r_buf == r_pin);
    assign w_fail_hit   = (({1'b0, r_fail_cnt}) + 3'd1) == 3'(MAX_FAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LOCKED;
            r_strobe_q  <= 1'b0;
            r_unlocked  <= 1'b0;
            r_alarm     <= 1'b0;
            r_buf       <= '0;
            r_pin       <= DEFAULT_PW;
            r_digit_cnt <= '0;
            r_fail_cnt  <= '0;
            r_alarm_cnt <= '0;
`ifdef AUTO_RELOCK_EN
            r_relock_cnt <= '0;
`endif
        end else begin
            r_strobe_q <= strobe;
`ifdef AUTO_RELOCK_EN
            // Held at zero outside OPEN, so it always starts fresh on OPEN entry.
            if (r_state != S_OPEN || w_press)
                r_relock_cnt <= '0;
            else if (r_relock_cnt != RELOCK_LAST)
                r_relock_cnt <= r_relock_cnt + RW'(1);
`endif
            case (r_state)
                S_LOCKED: begin
                    if (w_press && w_is_digit) begin
                        r_state     <= S_ENTRY;
                        r_buf       <= PWW'(key[3:0]);
                        r_digit_cnt <= 3'd1;
                    end
                end
                S_ENTRY: begin
                    if (w_press) begin
                        if (w_is_digit) begin
                            if (w_digit_room) begin
                                r_buf       <= w_buf_shift;
                                r_digit_cnt <= r_digit_cnt + 3'd1;
                            end
                        end else if (key == K_CLEAR) begin
                            r_state     <= S_LOCKED;
                            r_buf       <= '0;
                            r_digit_cnt <= '0;
                        end else if (key == K_ENTER) begin
                            r_buf       <= '0;
                            r_digit_cnt <= '0;
                            if (w_match) begin
                                r_state    <= S_OPEN;
                                r_unlocked <= 1'b1;
                                r_fail_cnt <= '0;
                            end else begin
                                if (r_fail_cnt != MAX_FAIL_C)
                                    r_fail_cnt <= r_fail_cnt + 2'd1;
                                if (w_fail_hit) begin
                                    r_state     <= S_ALARM;
                                    r_alarm     <= 1'b1;
                                    r_alarm_cnt <= ALARM_LAST;
                                end else begin
                                    r_state <= S_LOCKED;
                                end
                            end
                        end
                    end
                end
                S_OPEN: begin
                    if (w_press && key == K_LOCK) begin
                        r_state    <= S_LOCKED;
                        r_unlocked <= 1'b0;
                    end else if (w_press && key == K_SET) begin
                        r_state     <= S_SET_NEW;
                        r_buf       <= '0;
                        r_digit_cnt <= '0;
                    end
`ifdef AUTO_RELOCK_EN
                    else if (!w_press && r_relock_cnt == RELOCK_LAST) begin
                        r_state    <= S_LOCKED;
                        r_unlocked <= 1'b0;
                    end
`endif
                end
                S_SET_NEW: begin
                    if (w_press) begin
                        if (w_is_digit) begin
                            if (w_digit_room) begin
                                r_buf       <= w_buf_shift;
                                r_digit_cnt <= r_digit_cnt + 3'd1;
                            end
                        end else if (key == K_ENTER) begin
                            r_buf       <= '0;
                            r_digit_cnt <= '0;
                            if (r_digit_cnt == PW_LEN_C) begin
                                r_pin   <= r_buf;
                                r_state <= S_OPEN;
                            end
                        end else if (key == K_CLEAR || key == K_LOCK) begin
                            r_state     <= S_OPEN;
                            r_buf       <= '0;
                            r_digit_cnt <= '0;
                        end
                    end
                end
                S_ALARM: begin
                    if (r_alarm_cnt == '0) begin
                        r_state    <= S_LOCKED;
                        r_alarm    <= 1'b0;
                        r_fail_cnt <= '0;
                    end else begin
                        r_alarm_cnt <= r_alarm_cnt - AW'(1);
                    end
                end
                default: begin
                    r_state    <= S_LOCKED;
                    r_unlocked <= 1'b0;
                    r_alarm    <= 1'b0;
                end
            endcase
        end
    end

    assign unlocked  = r_unlocked;
    assign alarm     = r_alarm;
    assign state     = r_state;
    assign digit_cnt = r_digit_cnt;
    assign fail_cnt  = r_fail_cnt;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: directed press table, alarm/relock timing sequences and
// randomized key traffic checked every cycle against a digit-queue reference model.
module tb_lock_sequencer;
    localparam int          PW_LEN        = 4;
    localparam logic [15:0] DEF_PW        = 16'h1234;
    localparam int          MAX_FAIL      = 3;
    localparam int          ALARM_CYCLES  = 1000;
    localparam int          RELOCK_CYCLES = 5000;
    localparam int K_ENTER = 16, K_CLEAR = 17, K_LOCK = 18, K_SET = 19;
    localparam int M_LOCKED = 0, M_ENTRY = 1, M_OPEN = 2, M_SET = 3, M_ALARM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       strobe;
    logic [4:0] key;
    logic       unlocked;
    logic       alarm;
    logic [2:0] st;
    logic [2:0] dc;
    logic [1:0] fc;

    int n_vec = 0;
    int n_err = 0;

    lock_sequencer #(
        .PW_LEN(PW_LEN), .DEFAULT_PW(DEF_PW), .MAX_FAIL(MAX_FAIL),
        .ALARM_CYCLES(ALARM_CYCLES), .RELOCK_CYCLES(RELOCK_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .strobe(strobe), .key(key),
        .unlocked(unlocked), .alarm(alarm), .state(st),
        .digit_cnt(dc), .fail_cnt(fc)
    );

    always #5 clk = ~clk;

    // Reference model: PIN and entry kept as queues of decimal-style digits.
    int m_mode;
    int m_fails;
    int m_alarm_left;
    bit m_prev;
    int m_entry[$];
    int m_pin[$];
`ifdef AUTO_RELOCK_EN
    int m_idle;
`endif

    function automatic void model_reset();
        m_mode = M_LOCKED;
        m_fails = 0;
        m_alarm_left = 0;
        m_prev = 1'b0;
        m_entry.delete();
        m_pin.delete();
        for (int i = PW_LEN - 1; i >= 0; i--)
            m_pin.push_back(int'((DEF_PW >> (4 * i)) & 16'hF));
    endfunction

    function automatic bit entry_matches();
        if (m_entry.size() != PW_LEN) return 1'b0;
        foreach (m_entry[i]) if (m_entry[i] != m_pin[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_step(bit r, bit s, int k);
        bit press;
        bit ok;
        if (r) begin
            model_reset();
            return;
        end
        press = s && !m_prev;
        m_prev = s;
`ifdef AUTO_RELOCK_EN
        if (m_mode != M_OPEN) m_idle = 0;
`endif
        case (m_mode)
            M_LOCKED: if (press && k < 16) begin
                m_entry.delete();
                m_entry.push_back(k);
                m_mode = M_ENTRY;
            end
            M_ENTRY: if (press) begin
                if (k < 16) begin
                    if (m_entry.size() < PW_LEN) m_entry.push_back(k);
                end else if (k == K_CLEAR) begin
                    m_entry.delete();
                    m_mode = M_LOCKED;
                end else if (k == K_ENTER) begin
                    ok = entry_matches();
                    m_entry.delete();
                    if (ok) begin
                        m_mode = M_OPEN;
                        m_fails = 0;
                    end else if (m_fails + 1 == MAX_FAIL) begin
                        m_fails = MAX_FAIL;
                        m_mode = M_ALARM;
                        m_alarm_left = ALARM_CYCLES;
                    end else begin
                        m_fails = (m_fails + 1 > MAX_FAIL) ? MAX_FAIL : m_fails + 1;
                        m_mode = M_LOCKED;
                    end
                end
            end
            M_OPEN: begin
                if (press && k == K_LOCK) m_mode = M_LOCKED;
                else if (press && k == K_SET) begin
                    m_mode = M_SET;
                    m_entry.delete();
                end
`ifdef AUTO_RELOCK_EN
                else begin
                    m_idle = press ? 0 : m_idle + 1;
                    if (m_idle == RELOCK_CYCLES) m_mode = M_LOCKED;
                end
`endif
            end
            M_SET: if (press) begin
                if (k < 16) begin
                    if (m_entry.size() < PW_LEN) m_entry.push_back(k);
                end else if (k == K_ENTER) begin
                    if (m_entry.size() == PW_LEN) begin
                        m_pin = m_entry;
                        m_mode = M_OPEN;
                    end
                    m_entry.delete();
                end else if (k == K_CLEAR || k == K_LOCK) begin
                    m_entry.delete();
                    m_mode = M_OPEN;
                end
            end
            M_ALARM: begin
                m_alarm_left--;
                if (m_alarm_left == 0) begin
                    m_mode = M_LOCKED;
                    m_fails = 0;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic logic [9:0] model_exp();
        return {3'(m_mode), (m_mode == M_OPEN || m_mode == M_SET), (m_mode == M_ALARM),
                3'(m_entry.size()), 2'(m_fails)};
    endfunction

    function automatic logic [9:0] dut_out();
        return {st, unlocked, alarm, dc, fc};
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got st=%0d unl=%0b alm=%0b dc=%0d fc=%0d, want st=%0d unl=%0b alm=%0b dc=%0d fc=%0d",
                     name, $time, got[9:7], got[6], got[5], got[4:2], got[1:0],
                     exp[9:7], exp[6], exp[5], exp[4:2], exp[1:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [4:0] k);
        rst = r;
        strobe = s;
        key = k;
        @(posedge clk);
        model_step(r, s, int'(k));
        #1;
        check("model", dut_out(), model_exp());
    endtask

    task automatic press(input int k, input int hold, input int low);
        for (int i = 0; i < hold; i++) cyc(1'b0, 1'b1, 5'(k));
        for (int i = 0; i < low; i++) cyc(1'b0, 1'b0, 5'd0);
    endtask

    typedef struct {
        bit          r;
        int          k;
        int          hold;
        logic [9:0]  exp;
    } row_t;
    row_t tbl[$];

    function automatic void add(bit r, int k, int hold, int s, bit u, bit a, int d, int f);
        row_t x;
        x.r = r;
        x.k = k;
        x.hold = hold;
        x.exp = {3'(s), u, a, 3'(d), 2'(f)};
        tbl.push_back(x);
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before the test completed");
        $fatal(1);
    end

    initial begin
        int edges;
        rst = 1'b1;
        strobe = 1'b0;
        key = 5'd0;
        model_reset();

        //   r  key      hold st u a dc fc
        add(1, 0,        3,   0, 0, 0, 0, 0);
        add(0, K_ENTER,  3,   0, 0, 0, 0, 0);
        add(0, 25,       3,   0, 0, 0, 0, 0);
        add(0, 1,        3,   1, 0, 0, 1, 0);
        add(0, 2,        3,   1, 0, 0, 2, 0);
        add(0, 3,        3,   1, 0, 0, 3, 0);
        add(0, 4,        3,   1, 0, 0, 4, 0);
        add(0, K_ENTER,  3,   2, 1, 0, 0, 0);
        add(0, 1,        3,   2, 1, 0, 0, 0);
        add(0, K_LOCK,   3,   0, 0, 0, 0, 0);
        add(0, 5,        10,  1, 0, 0, 1, 0);
        add(0, K_CLEAR,  3,   0, 0, 0, 0, 0);
        add(0, 1,        3,   1, 0, 0, 1, 0);
        add(0, 2,        3,   1, 0, 0, 2, 0);
        add(0, 3,        3,   1, 0, 0, 3, 0);
        add(0, 4,        3,   1, 0, 0, 4, 0);
        add(0, 9,        3,   1, 0, 0, 4, 0);
        add(0, K_ENTER,  3,   2, 1, 0, 0, 0);
        add(0, K_SET,    3,   3, 1, 0, 0, 0);
        add(0, 7,        3,   3, 1, 0, 1, 0);
        add(0, 7,        3,   3, 1, 0, 2, 0);
        add(0, 7,        3,   3, 1, 0, 3, 0);
        add(0, 7,        3,   3, 1, 0, 4, 0);
        add(0, K_ENTER,  3,   2, 1, 0, 0, 0);
        add(0, K_LOCK,   3,   0, 0, 0, 0, 0);
        add(0, 1,        3,   1, 0, 0, 1, 0);
        add(0, 2,        3,   1, 0, 0, 2, 0);
        add(0, 3,        3,   1, 0, 0, 3, 0);
        add(0, 4,        3,   1, 0, 0, 4, 0);
        add(0, K_ENTER,  3,   0, 0, 0, 0, 1);
        add(0, 7,        3,   1, 0, 0, 1, 1);
        add(0, 7,        3,   1, 0, 0, 2, 1);
        add(0, 7,        3,   1, 0, 0, 3, 1);
        add(0, 7,        3,   1, 0, 0, 4, 1);
        add(0, K_ENTER,  3,   2, 1, 0, 0, 0);
        add(0, K_SET,    3,   3, 1, 0, 0, 0);
        add(0, 1,        3,   3, 1, 0, 1, 0);
        add(0, K_ENTER,  3,   3, 1, 0, 0, 0);
        add(0, K_CLEAR,  3,   2, 1, 0, 0, 0);
        add(0, K_LOCK,   3,   0, 0, 0, 0, 0);
        add(0, 1,        3,   1, 0, 0, 1, 0);
        add(0, 2,        3,   1, 0, 0, 2, 0);
        add(1, 0,        3,   0, 0, 0, 0, 0);
        add(0, 1,        3,   1, 0, 0, 1, 0);
        add(0, 2,        3,   1, 0, 0, 2, 0);
        add(0, 3,        3,   1, 0, 0, 3, 0);
        add(0, 4,        3,   1, 0, 0, 4, 0);
        add(0, K_ENTER,  3,   2, 1, 0, 0, 0);
        add(0, K_LOCK,   3,   0, 0, 0, 0, 0);
        add(0, 9,        3,   1, 0, 0, 1, 0);
        add(0, 9,        3,   1, 0, 0, 2, 0);
        add(0, 9,        3,   1, 0, 0, 3, 0);
        add(0, 9,        3,   1, 0, 0, 4, 0);
        add(0, K_ENTER,  3,   0, 0, 0, 0, 1);
        add(0, 1,        3,   1, 0, 0, 1, 1);
        add(0, K_ENTER,  3,   0, 0, 0, 0, 2);

        foreach (tbl[i]) begin
            if (tbl[i].r) begin
                cyc(1'b1, 1'b0, 5'd0);
                cyc(1'b1, 1'b0, 5'd0);
            end else begin
                press(tbl[i].k, tbl[i].hold, 3);
            end
            check($sformatf("row%0d", i), dut_out(), tbl[i].exp);
        end

        // Third bad attempt trips the alarm; time the lockout while keys are being pressed.
        for (int i = 0; i < 4; i++) press(9, 2, 2);
        cyc(1'b0, 1'b1, 5'(K_ENTER));
        check("alarm_entry", dut_out(), {3'd4, 1'b0, 1'b1, 3'd0, 2'd3});
        edges = 0;
        while (edges < ALARM_CYCLES + 50) begin
            cyc(1'b0, (edges % 4) < 2, ((edges % 8) < 4) ? 5'd1 : 5'd16);
            edges++;
            if (st != 3'd4) break;
        end
        check_int("alarm_len", edges, ALARM_CYCLES);
        cyc(1'b0, 1'b0, 5'd0);
        check("alarm_exit", dut_out(), {3'd0, 1'b0, 1'b0, 3'd0, 2'd0});

        for (int d = 1; d <= 4; d++) press(d, 2, 1);
        cyc(1'b0, 1'b1, 5'(K_ENTER));
        check("reopen", dut_out(), {3'd2, 1'b1, 1'b0, 3'd0, 2'd0});
`ifdef AUTO_RELOCK_EN
        edges = 0;
        while (edges < RELOCK_CYCLES + 50) begin
            cyc(1'b0, 1'b0, 5'd0);
            edges++;
            if (st != 3'd2) break;
        end
        check_int("relock_len", edges, RELOCK_CYCLES);
        check("relock_state", dut_out(), {3'd0, 1'b0, 1'b0, 3'd0, 2'd0});
`else
        for (int i = 0; i < RELOCK_CYCLES + 10; i++) cyc(1'b0, 1'b0, 5'd0);
        check("stay_open", dut_out(), {3'd2, 1'b1, 1'b0, 3'd0, 2'd0});
        press(K_LOCK, 2, 2);
        check("lock_after_idle", dut_out(), {3'd0, 1'b0, 1'b0, 3'd0, 2'd0});
`endif

        for (int b = 0; b < 400; b++) begin
            int sel;
            int pin_copy[$];
            int opts[12];
            opts = '{1, 2, 3, 4, 7, 9, 16, 17, 18, 19, 22, 31};
            sel = int'($urandom_range(0, 9));
            if (sel < 2) begin
                pin_copy = m_pin;
                foreach (pin_copy[j])
                    press(pin_copy[j], int'($urandom_range(1, 3)), int'($urandom_range(1, 2)));
                press(K_ENTER, 1, 1);
            end else if (sel == 2 && $urandom_range(0, 3) == 0) begin
                cyc(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            end else if (sel == 3) begin
                press(int'($urandom_range(0, 31)), int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
            end else begin
                press(opts[$urandom_range(0, 11)], int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
